// File: rtl/ctrl_frm_pkg.sv
// Shared constants and state encodings for the RS-485 command frame receiver.
package ctrl_frm_pkg;

    localparam logic [7:0] HDR    = 8'hA5;
    localparam logic [7:0] CMD_WR = 8'h01;
    localparam logic [7:0] CMD_RD = 8'h02;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_CHK
    } frm_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    function automatic logic [7:0] frame_chk(input logic [7:0] cmd,
                                             input logic [7:0] addr,
                                             input logic [7:0] data);
        return cmd ^ addr ^ data;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: synchroniser, mid-bit sampling, glitch rejection and framing check.
// state_dbg exposes the bit-engine state so the owner can derive activity from it.
module uart_rx_byte
    import ctrl_frm_pkg::*;
#(
    parameter int CLK_DIV = 434
) (
    input  logic       clk_sys,
    input  logic       rst,
    input  logic       rxd,
    output logic       byte_vld,
    output logic [7:0] byte_dat,
    output logic       frm_err,
    output rx_state_t  state_dbg
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLK_DIV - 1);

    logic [1:0]    r_sync;
    logic          r_rxd_prev;
    rx_state_t     r_state;
    rx_state_t     w_next;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          w_rxd;
    logic          w_tick;

    assign w_rxd     = r_sync[1];
    // The start bit is checked half a bit in; every later sample is one full bit apart.
    assign w_tick    = (r_state == RX_START) ? (r_cnt == HALF_M1) : (r_cnt == FULL_M1);
    assign byte_dat  = r_shift;
    assign state_dbg = r_state;

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            r_sync     <= 2'b11;
            r_rxd_prev <= 1'b1;
            r_state    <= RX_IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
        end else begin
            r_sync     <= {r_sync[0], rxd};
            r_rxd_prev <= w_rxd;
            r_state    <= w_next;
            if (r_state == RX_IDLE || r_state == RX_WAIT_HIGH || w_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (r_state == RX_START && w_tick) begin
                r_bit <= '0;
            end
            if (r_state == RX_DATA && w_tick) begin
                r_bit   <= r_bit + 3'd1;
                r_shift <= {w_rxd, r_shift[7:1]};
            end
        end
    end

    always_comb begin
        w_next   = r_state;
        byte_vld = 1'b0;
        frm_err  = 1'b0;
        case (r_state)
            RX_IDLE: begin
                if (r_rxd_prev && !w_rxd) begin
                    w_next = RX_START;
                end
            end
            RX_START: begin
                if (w_tick) begin
                    w_next = w_rxd ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (w_tick && r_bit == 3'd7) begin
                    w_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (w_tick) begin
                    byte_vld = w_rxd;
                    frm_err  = !w_rxd;
                    w_next   = w_rxd ? RX_IDLE : RX_WAIT_HIGH;
                end
            end
            RX_WAIT_HIGH: begin
                // A held-low line must not be mistaken for the next start bit.
                if (w_rxd) begin
                    w_next = RX_IDLE;
                end
            end
            default: w_next = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/ctrl_rx_frame.sv
// RS-485 command receiver: assembles HDR/CMD/ADDR/DATA/CHK frames and issues one fx
// write or read strobe per valid frame, counting framing, checksum and timeout errors.
module ctrl_rx_frame
    import ctrl_frm_pkg::*;
#(
    parameter int CLK_DIV    = 434,
    parameter int TIMEOUT_US = 200,
    parameter int AW         = 8,
    parameter int DW         = 8
) (
    input  logic          clk_sys,
    input  logic          rst,
    input  logic          pluse_us,
    input  logic          rx_ctrl,
    output logic [AW-1:0] fx_waddr,
    output logic [DW-1:0] fx_data,
    output logic          fx_wr,
    output logic [AW-1:0] fx_raddr,
    output logic          fx_rd,
    output logic [7:0]    err_cnt,
    output logic          busy
);

    localparam int GW = $clog2(TIMEOUT_US + 1);
    localparam logic [GW-1:0] GAP_MAX = GW'(TIMEOUT_US);

    logic       w_byte_vld;
    logic [7:0] w_byte_dat;
    logic       w_frm_err;
    rx_state_t  w_rx_state;
    logic       w_rx_active;

    frm_state_t    r_state;
    frm_state_t    w_next;
    logic [7:0]    r_cmd;
    logic [7:0]    r_addr;
    logic [7:0]    r_data;
    logic [GW-1:0] r_gap;
    logic [7:0]    r_err_cnt;
    logic          r_fx_wr;
    logic          r_fx_rd;
    logic [AW-1:0] r_waddr;
    logic [DW-1:0] r_wdata;
    logic [AW-1:0] r_raddr;
    logic          w_wr_go;
    logic          w_rd_go;
    logic          w_chk_err;
    logic          w_timeout;
    logic          w_err_inc;

    uart_rx_byte #(
        .CLK_DIV (CLK_DIV)
    ) u_rx (
        .clk_sys   (clk_sys),
        .rst       (rst),
        .rxd       (rx_ctrl),
        .byte_vld  (w_byte_vld),
        .byte_dat  (w_byte_dat),
        .frm_err   (w_frm_err),
        .state_dbg (w_rx_state)
    );

    assign w_rx_active = (w_rx_state != RX_IDLE);
    assign w_err_inc   = w_frm_err | w_chk_err | w_timeout;

    assign fx_wr    = r_fx_wr;
    assign fx_rd    = r_fx_rd;
    assign fx_waddr = r_waddr;
    assign fx_data  = r_wdata;
    assign fx_raddr = r_raddr;
    assign err_cnt  = r_err_cnt;
    assign busy     = (r_state != ST_IDLE) || w_rx_active;

    // A completed byte takes priority over a timeout reached in the same cycle.
    always_comb begin
        w_next    = r_state;
        w_wr_go   = 1'b0;
        w_rd_go   = 1'b0;
        w_chk_err = 1'b0;
        w_timeout = 1'b0;
        if (w_frm_err) begin
            w_next = ST_IDLE;
        end else if (w_byte_vld) begin
            case (r_state)
                ST_IDLE: if (w_byte_dat == HDR) w_next = ST_CMD;
                ST_CMD:  w_next = ST_ADDR;
                ST_ADDR: w_next = ST_DATA;
                ST_DATA: w_next = ST_CHK;
                ST_CHK: begin
                    w_next = ST_IDLE;
                    if (w_byte_dat == frame_chk(r_cmd, r_addr, r_data)) begin
                        w_wr_go = (r_cmd == CMD_WR);
                        w_rd_go = (r_cmd == CMD_RD);
                    end else begin
                        w_chk_err = 1'b1;
                    end
                end
                default: w_next = ST_IDLE;
            endcase
        end else if (r_state != ST_IDLE && r_gap == GAP_MAX) begin
            w_timeout = 1'b1;
            w_next    = ST_IDLE;
        end
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cmd     <= '0;
            r_addr    <= '0;
            r_data    <= '0;
            r_gap     <= '0;
            r_err_cnt <= '0;
            r_fx_wr   <= 1'b0;
            r_fx_rd   <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_raddr   <= '0;
        end else begin
            r_state <= w_next;
            if (w_byte_vld) begin
                case (r_state)
                    ST_CMD:  r_cmd  <= w_byte_dat;
                    ST_ADDR: r_addr <= w_byte_dat;
                    ST_DATA: r_data <= w_byte_dat;
                    default: ;
                endcase
            end
            // The gap timer only runs between bytes of a frame, never while one is arriving.
            if (w_byte_vld || r_state == ST_IDLE) begin
                r_gap <= '0;
            end else if (pluse_us && !w_rx_active && r_gap != GAP_MAX) begin
                r_gap <= r_gap + GW'(1);
            end
            r_fx_wr <= w_wr_go;
            r_fx_rd <= w_rd_go;
            if (w_wr_go) begin
                r_waddr <= AW'(r_addr);
                r_wdata <= DW'(r_data);
            end
            if (w_rd_go) begin
                r_raddr <= AW'(r_addr);
            end
            if (w_err_inc && r_err_cnt != 8'hFF) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_ctrl_rx_frame.sv
// Directed bench for ctrl_rx_frame: a driver serialises frames on rx_ctrl while a
// monitor compares every fx strobe against a queue of expected transactions.
module tb_ctrl_rx_frame;

    localparam int CLK_DIV    = 100;
    localparam int TIMEOUT_US = 200;
    localparam int US_CYC     = 10;
    localparam int W          = 17;

    logic       clk_sys  = 1'b0;
    logic       rst      = 1'b1;
    logic       pluse_us = 1'b0;
    logic       rx_ctrl  = 1'b1;
    logic [7:0] fx_waddr;
    logic [7:0] fx_data;
    logic       fx_wr;
    logic [7:0] fx_raddr;
    logic       fx_rd;
    logic [7:0] err_cnt;
    logic       busy;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_act;
    logic [W-1:0] mon_exp;

    ctrl_rx_frame #(
        .CLK_DIV    (CLK_DIV),
        .TIMEOUT_US (TIMEOUT_US),
        .AW         (8),
        .DW         (8)
    ) dut (
        .clk_sys  (clk_sys),
        .rst      (rst),
        .pluse_us (pluse_us),
        .rx_ctrl  (rx_ctrl),
        .fx_waddr (fx_waddr),
        .fx_data  (fx_data),
        .fx_wr    (fx_wr),
        .fx_raddr (fx_raddr),
        .fx_rd    (fx_rd),
        .err_cnt  (err_cnt),
        .busy     (busy)
    );

    // Clock and microsecond strobe
    always #5 clk_sys = ~clk_sys;

    initial begin
        forever begin
            repeat (US_CYC - 1) @(negedge clk_sys);
            pluse_us = 1'b1;
            @(negedge clk_sys);
            pluse_us = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: {is_read, addr, data}, data is 0 for reads
    always @(negedge clk_sys) begin
        if (!rst && (fx_wr || fx_rd)) begin
            check("wr_rd_exclusive", {31'd0, fx_wr & fx_rd}, 32'd0);
            mon_act = fx_rd ? {1'b1, fx_raddr, 8'h00} : {1'b0, fx_waddr, fx_data};
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got 0x%0h, expected no strobe", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                check("strobe", {15'd0, mon_act}, {15'd0, mon_exp});
            end
        end
    end

    // Driver tasks
    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx_ctrl = 1'b0;
        tick(CLK_DIV);
        for (int i = 0; i < 8; i++) begin
            rx_ctrl = b[i];
            tick(CLK_DIV);
        end
        rx_ctrl = stop;
        tick(CLK_DIV);
        rx_ctrl = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] a,
                              input logic [7:0] d, input logic [7:0] k);
        send_byte(8'hA5, 1'b1);
        send_byte(c, 1'b1);
        send_byte(a, 1'b1);
        send_byte(d, 1'b1);
        send_byte(k, 1'b1);
    endtask

    task automatic expect_wr(input logic [7:0] a, input logic [7:0] d);
        exp_q.push_back({1'b0, a, d});
    endtask

    task automatic expect_rd(input logic [7:0] a);
        exp_q.push_back({1'b1, a, 8'h00});
    endtask

    task automatic end_test(input string name, input logic [7:0] exp_err);
        int n;
        n = 0;
        while (busy && n < 5000) begin
            tick(1);
            n++;
        end
        tick(20);
        check({name, "_busy"}, {31'd0, busy}, 32'd0);
        check({name, "_pending"}, exp_q.size(), 32'd0);
        check({name, "_err_cnt"}, {24'd0, err_cnt}, {24'd0, exp_err});
    endtask

    task automatic do_reset();
        rx_ctrl = 1'b1;
        rst = 1'b1;
        tick(5);
        rst = 1'b0;
        tick(5);
    endtask

    initial begin
        do_reset();
        rst = 1'b1;
        tick(1);
        check("rst_fx_wr", {31'd0, fx_wr}, 32'd0);
        check("rst_fx_rd", {31'd0, fx_rd}, 32'd0);
        check("rst_fx_waddr", {24'd0, fx_waddr}, 32'd0);
        check("rst_fx_data", {24'd0, fx_data}, 32'd0);
        check("rst_fx_raddr", {24'd0, fx_raddr}, 32'd0);
        check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        tick(10);

        // 01^10^5C = 4D
        expect_wr(8'h10, 8'h5C);
        send_frame(8'h01, 8'h10, 8'h5C, 8'h4D);
        end_test("write", 8'd0);
        check("hold_waddr", {24'd0, fx_waddr}, 32'h10);
        check("hold_wdata", {24'd0, fx_data}, 32'h5C);

        // 02^22^00 = 20
        expect_rd(8'h22);
        send_frame(8'h02, 8'h22, 8'h00, 8'h20);
        end_test("read", 8'd0);
        check("read_keeps_waddr", {24'd0, fx_waddr}, 32'h10);
        check("read_raddr_hold", {24'd0, fx_raddr}, 32'h22);

        // Unknown command with a good checksum: 03^11^22 = 30
        send_frame(8'h03, 8'h11, 8'h22, 8'h30);
        end_test("unknown_cmd", 8'd0);

        send_frame(8'h01, 8'h10, 8'h5C, 8'h4E);
        end_test("bad_chk", 8'd1);

        // Timeout after a partial frame, then a good frame: 01^33^44 = 76
        do_reset();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        tick(250 * US_CYC);
        check("timeout_err_cnt", {24'd0, err_cnt}, 32'd1);
        check("timeout_idle", {31'd0, busy}, 32'd0);
        expect_wr(8'h33, 8'h44);
        send_frame(8'h01, 8'h33, 8'h44, 8'h76);
        end_test("after_timeout", 8'd1);

        // Framing error, then a short low glitch on the idle line
        do_reset();
        send_byte(8'h55, 1'b0);
        tick(50);
        check("frm_err_cnt", {24'd0, err_cnt}, 32'd1);
        rx_ctrl = 1'b0;
        tick(40);
        rx_ctrl = 1'b1;
        tick(200);
        check("glitch_idle", {31'd0, busy}, 32'd0);
        end_test("framing", 8'd1);

        // Reset in the middle of the ADDR byte, then a good frame: 01^7E^81 = FE
        do_reset();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        rx_ctrl = 1'b0;
        tick(CLK_DIV);
        rx_ctrl = 1'b1;
        tick(2 * CLK_DIV);
        rst = 1'b1;
        tick(2);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        rx_ctrl = 1'b1;
        tick(5);
        rst = 1'b0;
        tick(12 * CLK_DIV);
        check("mid_rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        expect_wr(8'h7E, 8'h81);
        send_frame(8'h01, 8'h7E, 8'h81, 8'hFE);
        end_test("after_rst", 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
